// File: rtl/noise_env_pkg.sv
// Shared types and constants for the shell/explosion noise envelope sequencer.
package noise_env_pkg;

    localparam int GAIN_W = 8;
    localparam int HOLD_W = 8;

    // Channel phase: silent, holding the peak, or decaying towards silence.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DECAY = 2'd2
    } env_state_t;

    // Exponential-ish decay step: a fixed fraction of the current level, never
    // less than 1 so the tail always reaches zero.
    function automatic logic [GAIN_W-1:0] decay_amount(input logic [GAIN_W-1:0] level,
                                                       input int unsigned     shift);
        logic [GAIN_W-1:0] d;
        d = level >> shift;
        if (d == '0) begin
            d = GAIN_W'(1);
        end
        return d;
    endfunction

endpackage

// File: rtl/noise_env_chan.sv
// One envelope channel: load a peak on trigger, hold it for HOLD ticks, then
// decay to zero by gain>>SHIFT (minimum 1) per tick.
module noise_env_chan
    import noise_env_pkg::*;
#(
    parameter int HOLD     = 20,
    parameter int SHIFT    = 3,
    parameter int LOUD_LVL = 255,
    parameter int SOFT_LVL = 96
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic              ls,
    input  logic              tick,
    output logic [GAIN_W-1:0] gain,
    output logic              active
);

    localparam logic [GAIN_W-1:0] LOUD_G    = GAIN_W'(LOUD_LVL);
    localparam logic [GAIN_W-1:0] SOFT_G    = GAIN_W'(SOFT_LVL);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD);

    env_state_t        state_reg, state_next;
    logic [GAIN_W-1:0] gain_reg, gain_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic              active_reg, active_next;
    logic [GAIN_W-1:0] dec_amt;

    assign dec_amt = decay_amount(gain_reg, SHIFT);

    // State register: phase, level, hold counter and the registered active flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            gain_reg   <= '0;
            hold_reg   <= '0;
            active_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            gain_reg   <= gain_next;
            hold_reg   <= hold_next;
            active_reg <= active_next;
        end
    end

    // Next-state logic: a trigger overrides everything, including a same-cycle tick.
    always_comb begin
        state_next = state_reg;
        gain_next  = gain_reg;
        hold_next  = hold_reg;
        if (trig) begin
            gain_next  = ls ? LOUD_G : SOFT_G;
            hold_next  = HOLD_INIT;
            state_next = ST_HOLD;
        end else if (tick) begin
            case (state_reg)
                ST_HOLD: begin
                    hold_next = hold_reg - HOLD_W'(1);
                    if (hold_reg == HOLD_W'(1)) begin
                        state_next = ST_DECAY;
                    end
                end
                ST_DECAY: begin
                    if (gain_reg <= dec_amt) begin
                        gain_next  = '0;
                        state_next = ST_IDLE;
                    end else begin
                        gain_next = gain_reg - dec_amt;
                    end
                end
                ST_IDLE: begin
                    gain_next = '0;
                end
                default: begin
                    gain_next  = '0;
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Output logic: active follows the next phase so it drops with the final zero.
    always_comb begin
        active_next = (state_next != ST_IDLE);
    end

    assign gain   = gain_reg;
    assign active = active_reg;

endmodule

// File: rtl/noise_env_ctrl.sv
// Envelope sequencer for the shell and explosion noise channels: trigger edge
// detection, a shared decay-tick prescaler and two envelope channels.
module noise_env_ctrl
    import noise_env_pkg::*;
#(
    parameter int DECAY_DIV   = 3000,
    parameter int SHELL_HOLD  = 20,
    parameter int EXPLO_HOLD  = 60,
    parameter int SHELL_SHIFT = 3,
    parameter int EXPLO_SHIFT = 5,
    parameter int LOUD_LVL    = 255,
    parameter int SOFT_LVL    = 96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_3MHz_en,
    input  logic       shell_ls,
    input  logic       shell_en,
    input  logic       explo_ls,
    input  logic       explo_en,
    output logic [7:0] shell_gain,
    output logic [7:0] explo_gain,
    output logic       shell_active,
    output logic       explo_active
);

    localparam int                CNT_W    = $clog2(DECAY_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DECAY_DIV - 1);

    logic [CNT_W-1:0]  count_reg;
    logic              tick;
    logic [1:0]        en_vec;
    logic [1:0]        ls_vec;
    logic [GAIN_W-1:0] gain_w [2];
    logic [1:0]        active_w;

    // Index 0 is the shell channel, index 1 the explosion channel.
    assign en_vec = {explo_en, shell_en};
    assign ls_vec = {explo_ls, shell_ls};

    // Free-running prescaler; triggers never touch it, so ticks stay on a fixed grid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clk_3MHz_en) begin
            count_reg <= (count_reg == CNT_LAST) ? '0 : count_reg + CNT_W'(1);
        end
    end

    assign tick = clk_3MHz_en & (count_reg == CNT_LAST);

    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        localparam int CH_HOLD  = (gi == 0) ? SHELL_HOLD  : EXPLO_HOLD;
        localparam int CH_SHIFT = (gi == 0) ? SHELL_SHIFT : EXPLO_SHIFT;

        logic en_q_reg;
        logic armed_reg;
        logic trig;

        // Edge detector. armed_reg only sets once en has been seen low, so an en
        // held high across reset release does not count as a fresh rising edge.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                en_q_reg  <= 1'b0;
                armed_reg <= 1'b0;
            end else begin
                en_q_reg  <= en_vec[gi];
                armed_reg <= armed_reg | ~en_vec[gi];
            end
        end

        assign trig = en_vec[gi] & ~en_q_reg & armed_reg;

        noise_env_chan #(
            .HOLD     (CH_HOLD),
            .SHIFT    (CH_SHIFT),
            .LOUD_LVL (LOUD_LVL),
            .SOFT_LVL (SOFT_LVL)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .trig   (trig),
            .ls     (ls_vec[gi]),
            .tick   (tick),
            .gain   (gain_w[gi]),
            .active (active_w[gi])
        );
    end

    assign shell_gain   = gain_w[0];
    assign explo_gain   = gain_w[1];
    assign shell_active = active_w[0];
    assign explo_active = active_w[1];

endmodule
